// File: rtl/gfp8_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : gfp8_result_collector
// Purpose  : Collects (mantissa, exponent) results from the GFP8 BCV
//            controller, packs RESULTS_PER_WORD of them per wide word and
//            buffers the packed words in a FIFO that drains over a
//            ready/valid handshake. The controller cannot be stalled, so
//            words that find the FIFO full are dropped and flagged.
// Ports    : i_clk, i_reset_n (async, active-low), i_clear (sync flush)
//            i_result_valid/_mantissa/_exponent, i_tile_done : result input
//            o_word_valid/_data/_count/_last, i_word_ready   : word output
//            o_collect_done, o_tile_count, o_busy, o_overflow : status
// Revision : 1.0 - initial release
// ============================================================================
module gfp8_result_collector #(
  parameter int RESULTS_PER_WORD = 4,
  parameter int FIFO_DEPTH       = 8
) (
  input  logic                                 i_clk,
  input  logic                                 i_reset_n,
  input  logic                                 i_clear,
  input  logic                                 i_result_valid,
  input  logic [31:0]                          i_result_mantissa,
  input  logic [7:0]                           i_result_exponent,
  input  logic                                 i_tile_done,
  output logic                                 o_word_valid,
  input  logic                                 i_word_ready,
  output logic [RESULTS_PER_WORD*40-1:0]       o_word_data,
  output logic [$clog2(RESULTS_PER_WORD+1)-1:0] o_word_count,
  output logic                                 o_word_last,
  output logic                                 o_collect_done,
  output logic [15:0]                          o_tile_count,
  output logic                                 o_busy,
  output logic                                 o_overflow
);

  localparam int LW = $clog2(RESULTS_PER_WORD);
  localparam int CW = $clog2(RESULTS_PER_WORD + 1);
  localparam int DW = RESULTS_PER_WORD * 40;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DW + CW + 1;   // {last, count, data}

  logic [LW-1:0] r_li;
  logic [DW-1:0] r_pack;
  logic [15:0]   r_cnt;
  logic [15:0]   r_tile_count;
  logic          r_overflow;
  logic          r_collect_done;
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [EW-1:0] r_mem [FIFO_DEPTH];

  logic [39:0]   w_in;
  logic [DW-1:0] w_word;
  logic [CW-1:0] w_count;
  logic          w_close;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_head;

  assign w_in    = {i_result_exponent, i_result_mantissa};
  assign w_close = (i_result_valid && (r_li == LW'(RESULTS_PER_WORD - 1))) || i_tile_done;
  assign w_count = CW'(r_li) + CW'(i_result_valid);

  // Packing register with this cycle's result merged into lane li. Lanes
  // beyond li are still zero because the register is cleared on each close.
  generate
    for (genvar k = 0; k < RESULTS_PER_WORD; k++) begin : g_lane
      assign w_word[40*k +: 40] = (i_result_valid && (r_li == LW'(k))) ? w_in
                                                                       : r_pack[40*k +: 40];
    end
  endgenerate

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[PW-1] != r_rptr[PW-1]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_head  = r_mem[r_rptr[AW-1:0]];
  assign w_pop   = !w_empty && i_word_ready;
  // A pop in the same cycle frees the head slot, which is the one written.
  assign w_push  = w_close && (!w_full || w_pop);
  assign w_drop  = w_close && w_full && !w_pop;

  // Head fields are masked while empty so stale entries never leak out.
  assign o_word_valid   = !w_empty;
  assign o_word_data    = w_empty ? '0 : w_head[DW-1:0];
  assign o_word_count   = w_empty ? '0 : w_head[DW +: CW];
  assign o_word_last    = w_empty ? 1'b0 : w_head[EW-1];
  assign o_collect_done = r_collect_done;
  assign o_tile_count   = r_tile_count;
  assign o_overflow     = r_overflow;
  assign o_busy         = (r_li != '0) || !w_empty || (r_cnt != '0);

  // Storage array needs no reset: entries are only observed between pointers.
  always_ff @(posedge i_clk) begin
    if (w_push && !i_clear) begin
      r_mem[r_wptr[AW-1:0]] <= {i_tile_done, w_count, w_word};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_li           <= '0;
      r_pack         <= '0;
      r_cnt          <= '0;
      r_tile_count   <= '0;
      r_overflow     <= 1'b0;
      r_collect_done <= 1'b0;
      r_wptr         <= '0;
      r_rptr         <= '0;
    end else if (i_clear) begin
      r_li           <= '0;
      r_pack         <= '0;
      r_cnt          <= '0;
      r_tile_count   <= '0;
      r_overflow     <= 1'b0;
      r_collect_done <= 1'b0;
      r_wptr         <= '0;
      r_rptr         <= '0;
    end else begin
      r_collect_done <= w_pop && w_head[EW-1];
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_drop) r_overflow <= 1'b1;

      if (w_close) begin
        r_li   <= '0;
        r_pack <= '0;
      end else if (i_result_valid) begin
        r_li   <= r_li + 1'b1;
        r_pack <= w_word;
      end

      if (i_tile_done) begin
        r_tile_count <= r_cnt + 16'(i_result_valid);
        r_cnt        <= '0;
      end else if (i_result_valid) begin
        r_cnt        <= r_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gfp8_result_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_gfp8_result_collector
// Purpose  : Self-checking bench for gfp8_result_collector. A queue-based
//            reference model tracks the tile in progress, the FIFO contents
//            and the status outputs; every cycle the DUT outputs are compared
//            against it. Directed scenarios are followed by random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gfp8_result_collector;

  localparam int RPW   = 4;
  localparam int DEPTH = 8;
  localparam int DW    = RPW * 40;
  localparam int CW    = $clog2(RPW + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_clear = 1'b0;
  logic          i_result_valid = 1'b0;
  logic [31:0]   i_result_mantissa = '0;
  logic [7:0]    i_result_exponent = '0;
  logic          i_tile_done = 1'b0;
  logic          i_word_ready = 1'b0;
  logic          o_word_valid;
  logic [DW-1:0] o_word_data;
  logic [CW-1:0] o_word_count;
  logic          o_word_last;
  logic          o_collect_done;
  logic [15:0]   o_tile_count;
  logic          o_busy;
  logic          o_overflow;

  int n_checks = 0;
  int n_errors = 0;

  gfp8_result_collector #(.RESULTS_PER_WORD(RPW), .FIFO_DEPTH(DEPTH)) u_dut (
    .i_clk             (clk),
    .i_reset_n         (rst_n),
    .i_clear           (i_clear),
    .i_result_valid    (i_result_valid),
    .i_result_mantissa (i_result_mantissa),
    .i_result_exponent (i_result_exponent),
    .i_tile_done       (i_tile_done),
    .o_word_valid      (o_word_valid),
    .i_word_ready      (i_word_ready),
    .o_word_data       (o_word_data),
    .o_word_count      (o_word_count),
    .o_word_last       (o_word_last),
    .o_collect_done    (o_collect_done),
    .o_tile_count      (o_tile_count),
    .o_busy            (o_busy),
    .o_overflow        (o_overflow)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    logic [DW-1:0] data;
    int            cnt;
    logic          last;
  } word_t;

  word_t       m_q[$];
  logic [39:0] m_lanes[$];
  logic [15:0] m_cnt;
  logic [15:0] m_tcnt;
  logic        m_ovf;
  logic        m_done;

  task automatic model_reset();
    m_q.delete();
    m_lanes.delete();
    m_cnt  = '0;
    m_tcnt = '0;
    m_ovf  = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_step();
    word_t w;
    bit    pop;
    if (i_clear) begin
      model_reset();
      return;
    end
    pop    = (m_q.size() > 0) && i_word_ready;
    m_done = 1'b0;
    if (pop) begin
      m_done = m_q[0].last;
      void'(m_q.pop_front());
    end
    if (i_result_valid) begin
      m_lanes.push_back({i_result_exponent, i_result_mantissa});
      m_cnt = m_cnt + 16'd1;
    end
    if (m_lanes.size() == RPW || i_tile_done) begin
      w.data = '0;
      for (int i = 0; i < m_lanes.size(); i++) w.data[i*40 +: 40] = m_lanes[i];
      w.cnt  = m_lanes.size();
      w.last = i_tile_done;
      if (m_q.size() < DEPTH) m_q.push_back(w);
      else                    m_ovf = 1'b1;
      m_lanes.delete();
    end
    if (i_tile_done) begin
      m_tcnt = m_cnt;
      m_cnt  = '0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [191:0] act, input logic [191:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit            v;
    logic [DW-1:0] d;
    int            c;
    logic          l;
    v = (m_q.size() > 0);
    d = v ? m_q[0].data : '0;
    c = v ? m_q[0].cnt  : 0;
    l = v ? m_q[0].last : 1'b0;
    chk("word_valid",   192'(o_word_valid),   192'(v));
    chk("word_data",    192'(o_word_data),    192'(d));
    chk("word_count",   192'(o_word_count),   192'(c));
    chk("word_last",    192'(o_word_last),    192'(l));
    chk("collect_done", 192'(o_collect_done), 192'(m_done));
    chk("tile_count",   192'(o_tile_count),   192'(m_tcnt));
    chk("overflow",     192'(o_overflow),     192'(m_ovf));
    chk("busy",         192'(o_busy),
        192'((m_lanes.size() > 0) || (m_q.size() > 0) || (m_cnt != 0)));
  endtask

  task automatic step(input bit v, input bit d, input bit rdy, input bit clr);
    @(negedge clk);
    check_outputs();
    i_result_valid    = v;
    i_result_mantissa = $urandom;
    i_result_exponent = 8'($urandom);
    i_tile_done       = d;
    i_word_ready      = rdy;
    i_clear           = clr;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(0, 0, rdy, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    #1 chk("reset_valid", 192'(o_word_valid), 192'(0));
    chk("reset_busy", 192'(o_busy), 192'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(2, 1);

    // Single full tile of 4 results, done on the 4th.
    for (int i = 0; i < 4; i++) step(1, i == 3, 1, 0);
    idle(4, 1);
    chk("t1_tile_count", 192'(o_tile_count), 192'(4));

    // Six-result tile: one full and one partial word.
    for (int i = 0; i < 6; i++) step(1, i == 5, 1, 0);
    idle(4, 1);
    chk("t2_tile_count", 192'(o_tile_count), 192'(6));

    // Stalled sink, 40 results: 8 words held, 2 dropped.
    for (int i = 0; i < 40; i++) step(1, 0, 0, 0);
    idle(3, 0);
    chk("t3_overflow", 192'(o_overflow), 192'(1));
    chk("t3_valid",    192'(o_word_valid), 192'(1));
    idle(12, 1);
    chk("t3_drained",  192'(o_word_valid), 192'(0));
    step(0, 0, 1, 1);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 32; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++)  step(1, 0, 1, 0);
    idle(12, 1);
    chk("t4_no_overflow", 192'(o_overflow), 192'(0));
    step(0, 0, 1, 1);

    // Lone tile_done with empty packer, then clear.
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    chk("t5_empty_count", 192'(o_word_count), 192'(0));
    chk("t5_empty_last",  192'(o_word_last),  192'(1));
    chk("t5_tile_count",  192'(o_tile_count), 192'(0));
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    chk("t5_clr_valid", 192'(o_word_valid), 192'(0));
    chk("t5_clr_ovf",   192'(o_overflow),   192'(0));
    chk("t5_clr_busy",  192'(o_busy),       192'(0));

    // Asynchronous reset mid-tile.
    for (int i = 0; i < 3; i++) step(1, 0, 1, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_busy",  192'(o_busy),       192'(0));
    chk("t6_rst_valid", 192'(o_word_valid), 192'(0));
    chk("t6_rst_tcnt",  192'(o_tile_count), 192'(0));
    check_outputs();
    i_result_valid = 1'b0;
    i_tile_done    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) step(1, i == 3, 1, 0);
    idle(3, 1);
    chk("t6_tile_count", 192'(o_tile_count), 192'(4));

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 99) == 0);
    end
    idle(20, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
